// File: rtl/bar_pattern_gen.sv
// bar_pattern_gen: colour-bar test-pattern generator placed between VGA timing and the colour pins.
// It produces vertical bars, horizontal bars or a checkerboard from a palette of 2..8 colours.
// The pattern can scroll by a fixed step on every frame. Mode and scroll controls are shadowed
// and take effect only on frame_tick, so the picture never tears mid-frame.
// Ports:
//   clk_0       pixel clock
//   rst         synchronous reset, active-high
//   pixel_x/y   current pixel column / line (10 bits)
//   video_on    1 = active video region
//   frame_tick  one-cycle pulse per frame, in vertical blanking
//   mode        0 vertical, 1 horizontal, 2 checker, 3 vertical
//   scroll_en   advance the offset on every frame_tick
//   scroll_dir  0 = pattern moves left/up, 1 = right/down
//   red/green/blue  registered colour channels, COLOUR_BITS wide each
module bar_pattern_gen #(
  parameter int unsigned H_VIDEO     = 640,
  parameter int unsigned V_VIDEO     = 480,
  parameter int unsigned COLOUR_BITS = 4,
  parameter int unsigned NUM_COLOURS = 3,
  parameter int unsigned BAR_WIDTH   = 20,
  parameter int unsigned SCROLL_STEP = 4
) (
  input  logic                   clk_0,
  input  logic                   rst,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   video_on,
  input  logic                   frame_tick,
  input  logic [1:0]             mode,
  input  logic                   scroll_en,
  input  logic                   scroll_dir,
  output logic [COLOUR_BITS-1:0] red,
  output logic [COLOUR_BITS-1:0] green,
  output logic [COLOUR_BITS-1:0] blue
);

  localparam int unsigned PosW = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
  localparam logic [PosW-1:0] PosLast = PosW'(BAR_WIDTH - 1);
  localparam logic [PosW:0]   BarW    = (PosW + 1)'(BAR_WIDTH);
  localparam logic [PosW:0]   Step    = (PosW + 1)'(SCROLL_STEP);
  localparam logic [2:0]      IdxLast = 3'(NUM_COLOURS - 1);
  localparam logic [3:0]      NumC    = 4'(NUM_COLOURS);
  localparam logic [10:0]     HVid    = 11'(H_VIDEO);
  localparam logic [10:0]     VVid    = 11'(V_VIDEO);

  logic [1:0]      mode_q, mode_d;
  logic            scroll_en_q, scroll_en_d, scroll_dir_q, scroll_dir_d;
  logic [PosW-1:0] off_pos_q, off_pos_d, col_pos_q, col_pos_d, row_pos_q, row_pos_d;
  logic [2:0]      off_idx_q, off_idx_d, col_idx_q, col_idx_d, row_idx_q, row_idx_d;
  logic [COLOUR_BITS-1:0] red_d, green_d, blue_d;

  logic            active, vert_mode, horz_mode;
  logic [PosW:0]   pos_ext, sum_fwd;
  logic [3:0]      idx_sum;
  logic [2:0]      disp_idx;
  logic [2:0]      rgb_on;

  function automatic logic [2:0] idx_inc(input logic [2:0] i);
    return (i == IdxLast) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] idx_dec(input logic [2:0] i);
    return (i == 3'd0) ? IdxLast : i - 3'd1;
  endfunction

  // {r,g,b} on/off for each palette entry.
  function automatic logic [2:0] palette(input logic [2:0] i);
    logic [2:0] c;
    case (i)
      3'd0:    c = 3'b100;
      3'd1:    c = 3'b010;
      3'd2:    c = 3'b001;
      3'd3:    c = 3'b110;
      3'd4:    c = 3'b011;
      3'd5:    c = 3'b101;
      3'd6:    c = 3'b111;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  assign active    = video_on && ({1'b0, pixel_x} < HVid) && ({1'b0, pixel_y} < VVid);
  assign vert_mode = (mode_q == 2'd0) || (mode_q == 2'd3);
  assign horz_mode = (mode_q == 2'd1);
  assign pos_ext   = {1'b0, off_pos_q};
  assign sum_fwd   = pos_ext + Step;

  // Shadow controls and scroll offset. Scrolling uses the values captured on this same tick.
  always_comb begin
    mode_d       = mode_q;
    scroll_en_d  = scroll_en_q;
    scroll_dir_d = scroll_dir_q;
    off_pos_d    = off_pos_q;
    off_idx_d    = off_idx_q;
    if (frame_tick) begin
      mode_d       = mode;
      scroll_en_d  = scroll_en;
      scroll_dir_d = scroll_dir;
    end
    if (frame_tick && scroll_en_d) begin
      if (!scroll_dir_d) begin
        if (sum_fwd >= BarW) begin
          off_pos_d = PosW'(sum_fwd - BarW);
          off_idx_d = idx_inc(off_idx_q);
        end else begin
          off_pos_d = sum_fwd[PosW-1:0];
        end
      end else begin
        if (pos_ext >= Step) begin
          off_pos_d = PosW'(pos_ext - Step);
        end else begin
          off_pos_d = PosW'(pos_ext + BarW - Step);
          off_idx_d = idx_dec(off_idx_q);
        end
      end
    end
  end

  // Counter _d values describe the pixel presented this cycle; colour is derived from them.
  always_comb begin
    col_pos_d = col_pos_q;
    col_idx_d = col_idx_q;
    row_pos_d = row_pos_q;
    row_idx_d = row_idx_q;
    if (active) begin
      if (pixel_x == 10'd0) begin
        col_pos_d = vert_mode ? off_pos_q : '0;
        col_idx_d = vert_mode ? off_idx_q : 3'd0;
      end else if (col_pos_q == PosLast) begin
        col_pos_d = '0;
        col_idx_d = idx_inc(col_idx_q);
      end else begin
        col_pos_d = col_pos_q + 1'b1;
      end

      if (pixel_x == 10'd0) begin
        if (pixel_y == 10'd0) begin
          row_pos_d = horz_mode ? off_pos_q : '0;
          row_idx_d = horz_mode ? off_idx_q : 3'd0;
        end else if (row_pos_q == PosLast) begin
          row_pos_d = '0;
          row_idx_d = idx_inc(row_idx_q);
        end else begin
          row_pos_d = row_pos_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, col_idx_d} + {1'b0, row_idx_d};
    if (idx_sum >= NumC) idx_sum = idx_sum - NumC;
    case (mode_q)
      2'd1:    disp_idx = row_idx_d;
      2'd2:    disp_idx = idx_sum[2:0];
      default: disp_idx = col_idx_d;
    endcase
    rgb_on  = active ? palette(disp_idx) : 3'b000;
    red_d   = {COLOUR_BITS{rgb_on[2]}};
    green_d = {COLOUR_BITS{rgb_on[1]}};
    blue_d  = {COLOUR_BITS{rgb_on[0]}};
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      mode_q       <= 2'd0;
      scroll_en_q  <= 1'b0;
      scroll_dir_q <= 1'b0;
      off_pos_q    <= '0;
      off_idx_q    <= 3'd0;
      col_pos_q    <= '0;
      col_idx_q    <= 3'd0;
      row_pos_q    <= '0;
      row_idx_q    <= 3'd0;
      red          <= '0;
      green        <= '0;
      blue         <= '0;
    end else begin
      mode_q       <= mode_d;
      scroll_en_q  <= scroll_en_d;
      scroll_dir_q <= scroll_dir_d;
      off_pos_q    <= off_pos_d;
      off_idx_q    <= off_idx_d;
      col_pos_q    <= col_pos_d;
      col_idx_q    <= col_idx_d;
      row_pos_q    <= row_pos_d;
      row_idx_q    <= row_idx_d;
      red          <= red_d;
      green        <= green_d;
      blue         <= blue_d;
    end
  end

endmodule
